// File: rtl/baud_scheduler.sv
// UART baud timebase: divisor counter with tick-aligned divisor updates,
// plus TX bit-phase and RX mid-bit sample scheduling off the 16x tick.
module baud_scheduler #(
    parameter int          DIV_W       = 22,
    parameter int unsigned DEFAULT_DIV = 162
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_wdata,
    output logic [DIV_W-1:0] div_rdata,
    output logic             div_pending,
    output logic             tick16,
    input  logic             tx_start,
    input  logic             tx_done,
    output logic             tx_bit_tick,
    output logic             tx_busy,
    input  logic             rx_start,
    input  logic             rx_done,
    output logic             rx_sample,
    output logic             rx_busy
);

    typedef enum logic {
        TX_IDLE,
        TX_RUN
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA
    } rx_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_active;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] wdata_fix;
    logic             pending;
    logic             apply;

    tx_state_t        tx_state;
    logic [3:0]       tx_phase;
    rx_state_t        rx_state;
    logic [3:0]       rx_phase;

    assign tick16    = en & (div_cnt == div_active);
    // While disabled there is no tick to wait for, so apply straight away.
    assign apply     = pending & (tick16 | ~en);
    assign wdata_fix = (div_wdata == '0) ? DIV_W'(1) : div_wdata;

    assign div_rdata   = div_active;
    assign div_pending = pending;

    assign tx_busy     = (tx_state == TX_RUN);
    assign tx_bit_tick = tick16 & tx_busy & (tx_phase == 4'hF) & ~tx_done;

    assign rx_busy   = (rx_state != RX_IDLE);
    assign rx_sample = tick16 & ~rx_done &
                       (((rx_state == RX_START) & (rx_phase == 4'd7)) |
                        ((rx_state == RX_DATA) & (rx_phase == 4'hF)));

    // Divisor counter, shadow register and tick-boundary apply.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt    <= '0;
            div_active <= DIV_W'(DEFAULT_DIV);
            shadow     <= '0;
            pending    <= 1'b0;
        end else begin
            if (!en || tick16) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (apply) begin
                div_active <= shadow;
            end
            if (div_wr) begin
                shadow  <= wdata_fix;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    // TX bit-phase sequencer: one bit boundary per 16 oversample ticks.
    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            tx_state <= TX_IDLE;
            tx_phase <= '0;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (tx_start && !tx_done) begin
                        tx_state <= TX_RUN;
                        tx_phase <= '0;
                    end
                end
                TX_RUN: begin
                    if (tx_done) begin
                        tx_state <= TX_IDLE;
                        tx_phase <= '0;
                    end else if (tick16) begin
                        tx_phase <= tx_phase + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_phase <= '0;
                end
            endcase
        end
    end

    // RX sampler: half-bit wait to the start-bit centre, then every bit.
    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            rx_state <= RX_IDLE;
            rx_phase <= '0;
        end else begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (rx_start && !rx_done) begin
                        rx_state <= RX_START;
                        rx_phase <= '0;
                    end
                end
                RX_START: begin
                    if (rx_done) begin
                        rx_state <= RX_IDLE;
                        rx_phase <= '0;
                    end else if (tick16) begin
                        if (rx_phase == 4'd7) begin
                            rx_state <= RX_DATA;
                            rx_phase <= '0;
                        end else begin
                            rx_phase <= rx_phase + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_done) begin
                        rx_state <= RX_IDLE;
                        rx_phase <= '0;
                    end else if (tick16) begin
                        rx_phase <= rx_phase + 1'b1;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                    rx_phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baud_scheduler.sv
// Bench for baud_scheduler: directed timing pins followed by random traffic,
// all cycles compared against an event-time model of the timebase.
module tb_baud_scheduler;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic        div_wr = 1'b0;
    logic [21:0] div_wdata = '0;
    logic [21:0] div_rdata;
    logic        div_pending;
    logic        tick16;
    logic        tx_start = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_bit_tick;
    logic        tx_busy;
    logic        rx_start = 1'b0;
    logic        rx_done = 1'b0;
    logic        rx_sample;
    logic        rx_busy;

    int checks = 0;
    int errors = 0;

    baud_scheduler #(
        .DIV_W(22),
        .DEFAULT_DIV(162)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .en(en),
        .div_wr(div_wr),
        .div_wdata(div_wdata),
        .div_rdata(div_rdata),
        .div_pending(div_pending),
        .tick16(tick16),
        .tx_start(tx_start),
        .tx_done(tx_done),
        .tx_bit_tick(tx_bit_tick),
        .tx_busy(tx_busy),
        .rx_start(rx_start),
        .rx_done(rx_done),
        .rx_sample(rx_sample),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: absolute cycle of the next tick, plus tick counts
    // since each frame started.
    longint cyc_n = 0;
    longint nxt = 0;
    int     m_act = 162;
    int     m_sh = 0;
    bit     m_pend = 0;
    bit     m_ok = 0;
    bit     m_tx = 0;
    bit     m_rx = 0;
    int     m_txk = 0;
    int     m_rxk = 0;

    always @(negedge clk) begin
        bit tk;
        bit ap;
        bit ex_tb;
        bit ex_rs;
        int k;
        tk = en && (cyc_n == nxt);
        ex_tb = tk && m_tx && !tx_done && ((m_txk + 1) % 16 == 0);
        k = m_rxk + 1;
        ex_rs = tk && m_rx && !rx_done &&
                (k == 8 || (k > 8 && (k - 8) % 16 == 0));
        if (m_ok) begin
            chk("tick16", tick16, tk);
            chk("div_rdata", div_rdata, m_act);
            chk("div_pending", div_pending, m_pend);
            chk("tx_bit_tick", tx_bit_tick, ex_tb);
            chk("tx_busy", tx_busy, m_tx);
            chk("rx_sample", rx_sample, ex_rs);
            chk("rx_busy", rx_busy, m_rx);
        end
        if (!resetn) begin
            m_act = 162;
            m_sh = 0;
            m_pend = 0;
            m_tx = 0;
            m_rx = 0;
            m_txk = 0;
            m_rxk = 0;
            nxt = cyc_n + 1 + 162;
            m_ok = 1;
        end else if (m_ok) begin
            ap = m_pend && (tk || !en);
            if (ap) m_act = m_sh;
            if (div_wr) begin
                m_sh = (div_wdata == 0) ? 1 : int'(div_wdata);
                m_pend = 1;
            end else if (ap) begin
                m_pend = 0;
            end
            if (!en) begin
                nxt = cyc_n + 1 + m_act;
                m_tx = 0;
                m_rx = 0;
                m_txk = 0;
                m_rxk = 0;
            end else begin
                if (tk) nxt = cyc_n + 1 + m_act;
                if (m_tx) begin
                    if (tx_done) begin
                        m_tx = 0;
                        m_txk = 0;
                    end else if (tk) begin
                        m_txk++;
                    end
                end else if (tx_start && !tx_done) begin
                    m_tx = 1;
                    m_txk = 0;
                end
                if (m_rx) begin
                    if (rx_done) begin
                        m_rx = 0;
                        m_rxk = 0;
                    end else if (tk) begin
                        m_rxk++;
                    end
                end else if (rx_start && !rx_done) begin
                    m_rx = 1;
                    m_rxk = 0;
                end
            end
        end
        cyc_n++;
    end

    int early_ticks[$];
    int rq[$];
    int tq[$];
    int nt = 0;
    int late = 0;

    initial begin
        repeat (3) cyc();
        #3;
        chk("rst_rdata", div_rdata, 162);
        chk("rst_pending", div_pending, 0);
        chk("rst_tick", tick16, 0);
        chk("rst_busy", {tx_busy, rx_busy}, 0);
        cyc();

        for (int c = 0; c < 600; c++) begin
            div_wr = 0;
            tx_start = 0;
            tx_done = 0;
            rx_start = 0;
            rx_done = 0;
            en = (c != 550);
            resetn = (c != 560);
            case (c)
                50:  begin div_wr = 1; div_wdata = 22'd9; end
                205: begin div_wr = 1; div_wdata = 22'd0; end
                214: begin div_wr = 1; div_wdata = 22'd5; end
                216: begin div_wr = 1; div_wdata = 22'd7; end
                240: begin div_wr = 1; div_wdata = 22'd3; end
                260: begin tx_start = 1; rx_start = 1; end
                400: begin rx_done = 1; tx_done = 1; tx_start = 1; end
                500: begin tx_start = 1; rx_start = 1; end
                default: ;
            endcase
            #3;
            if (tick16 && c < 200) early_ticks.push_back(c);
            if (c > 260 && c < 400) begin
                if (tick16) nt++;
                if (rx_sample) rq.push_back(nt);
                if (tx_bit_tick) tq.push_back(nt);
            end
            if (c > 400 && c < 500 && (rx_sample || tx_bit_tick)) late++;
            case (c)
                100: chk("wr9_pending", div_pending, 1);
                170: begin
                    chk("wr9_applied_pend", div_pending, 0);
                    chk("wr9_rdata", div_rdata, 9);
                end
                210: chk("wr0_pending", div_pending, 1);
                214: begin
                    chk("div1_rdata", div_rdata, 1);
                    chk("div1_tick", tick16, 1);
                end
                215: chk("div1_notick", tick16, 0);
                217: begin
                    chk("coll_rdata", div_rdata, 5);
                    chk("coll_pending", div_pending, 1);
                end
                222: chk("coll_tick", tick16, 1);
                223: begin
                    chk("coll2_rdata", div_rdata, 7);
                    chk("coll2_pending", div_pending, 0);
                end
                230: chk("div7_tick", tick16, 1);
                248: chk("div3_rdata", div_rdata, 3);
                401: chk("done_busy", {tx_busy, rx_busy}, 0);
                549: chk("run_busy", {tx_busy, rx_busy}, 2'b11);
                551: begin
                    chk("en0_busy", {tx_busy, rx_busy}, 0);
                    chk("en0_strobes", {tick16, rx_sample, tx_bit_tick}, 0);
                end
                560: chk("pre_rst_rdata", div_rdata, 3);
                561: begin
                    chk("rst2_rdata", div_rdata, 162);
                    chk("rst2_pending", div_pending, 0);
                    chk("rst2_busy", {tx_busy, rx_busy}, 0);
                end
                default: ;
            endcase
            cyc();
        end

        chk("early_nticks", early_ticks.size(), 4);
        if (early_ticks.size() >= 2) begin
            chk("first_tick", early_ticks[0], 162);
            chk("tick_after_apply", early_ticks[1], 172);
        end
        chk("rx_nsamples", rq.size(), 2);
        if (rq.size() >= 2) begin
            chk("rx_first_sample", rq[0], 8);
            chk("rx_second_sample", rq[1], 24);
        end
        chk("tx_nbits", tq.size(), 2);
        if (tq.size() >= 2) begin
            chk("tx_first_bit", tq[0], 16);
            chk("tx_second_bit", tq[1], 32);
        end
        chk("strobes_after_done", late, 0);

        for (int i = 0; i < 4000; i++) begin
            resetn = ($urandom % 600) != 0;
            en = ($urandom % 80) != 0;
            div_wr = ($urandom % 40) == 0;
            div_wdata = 22'($urandom % 8);
            tx_start = ($urandom % 20) == 0;
            tx_done = ($urandom % 160) == 0;
            rx_start = ($urandom % 20) == 0;
            rx_done = ($urandom % 160) == 0;
            cyc();
        end

        resetn = 1;
        en = 1;
        div_wr = 0;
        tx_start = 0;
        tx_done = 0;
        rx_start = 0;
        rx_done = 0;
        repeat (4) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
